// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
// Shared definitions for the instruction-fetch stage of the five-stage MIPS
// pipeline: reset PC, instruction-memory depth and the canonical NOP encoding,
// plus the fetch-window legality check used when capturing into IF/ID.
// -----------------------------------------------------------------------------
package if_stage_pkg;

  // Base of instruction memory and the PC value loaded on reset.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // Instruction memory size in 32-bit words.
  localparam int unsigned IM_DEPTH_DEFAULT = 4096;

  // sll $0,$0,0 -- the all-zero word doubles as bubble and illegal-fetch filler.
  localparam logic [31:0] NOP = 32'h0000_0000;

  // Returns 1 when a fetch from pc is outside the word-aligned window
  // [base, base + 4*depth). The limit is computed in 33 bits so a window that
  // ends exactly at 2^32 does not wrap to zero and reject every address.
  function automatic logic addr_illegal(input logic [31:0] pc,
                                        input logic [31:0] base,
                                        input int unsigned depth);
    logic [32:0] lim;
    lim = {1'b0, base} + (33'(depth) << 2);
    return (pc[1:0] != 2'b00) || (pc < base) || ({1'b0, pc} >= lim);
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// -----------------------------------------------------------------------------
// if_stage_if
// Bundles every non-clock/reset signal of the fetch stage.
//   Hazard unit -> IF : stall, flush
//   D stage     -> IF : redirect, target
//   IF <-> IM         : pc_f (address out), instr_f (read data in, same cycle)
//   IF -> D           : instr_d, pc_d, pc8_d, valid_d, adel_d
// Modport master is the fetch stage itself; slave is its environment
// (hazard unit, decode, instruction memory).
// -----------------------------------------------------------------------------
interface if_stage_if;

  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_f;
  logic [31:0] instr_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        valid_d;
  logic        adel_d;

  modport master (
    input  stall,
    input  flush,
    input  redirect,
    input  target,
    input  instr_f,
    output pc_f,
    output instr_d,
    output pc_d,
    output pc8_d,
    output valid_d,
    output adel_d
  );

  modport slave (
    output stall,
    output flush,
    output redirect,
    output target,
    output instr_f,
    input  pc_f,
    input  instr_d,
    input  pc_d,
    input  pc8_d,
    input  valid_d,
    input  adel_d
  );

endinterface

// File: rtl/if_stage_pc_unit.sv
// -----------------------------------------------------------------------------
// if_stage_pc_unit
// PC register, pending-redirect latch and next-PC priority mux.
// Ports:
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous, active-high reset
//   i_stall    in   1   hold the PC this cycle
//   i_redirect in   1   taken branch/jump resolved in D, i_target valid
//   i_target   in   32  redirect destination
//   o_pc       out  32  current fetch address
// A redirect that arrives while stalled cannot be applied yet, so it is parked
// in the pending latch and replayed on the first non-stalled edge. A newer
// redirect under stall simply overwrites the parked target.
// -----------------------------------------------------------------------------
module if_stage_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_target,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;
  logic        r_pend_v;
  logic [31:0] r_pend_target;

  logic [31:0] w_pc_next;
  logic        w_pend_v_next;
  logic [31:0] w_pend_target_next;

  always_comb begin
    w_pc_next          = r_pc + 32'd4;  // wraps modulo 2^32
    w_pend_v_next      = r_pend_v;
    w_pend_target_next = r_pend_target;

    if (i_stall) begin
      w_pc_next = r_pc;
      if (i_redirect) begin
        w_pend_v_next      = 1'b1;
        w_pend_target_next = i_target;
      end
    end else if (i_redirect) begin
      // A live redirect is newer than anything parked, so it wins.
      w_pc_next     = i_target;
      w_pend_v_next = 1'b0;
    end else if (r_pend_v) begin
      w_pc_next     = r_pend_target;
      w_pend_v_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_pend_v      <= 1'b0;
      r_pend_target <= 32'h0000_0000;
    end else begin
      r_pc          <= w_pc_next;
      r_pend_v      <= w_pend_v_next;
      r_pend_target <= w_pend_target_next;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage of the five-stage MIPS pipeline. Owns the PC (via
// if_stage_pc_unit) and the IF/ID pipeline register, drives the fetch address
// to instruction memory and captures the returned word.
// Parameters:
//   RESET_PC  PC loaded on reset; base of instruction memory
//   IM_DEPTH  instruction memory size in words; defines the legal fetch window
// Ports:
//   clk    in  1   clock, rising edge
//   reset  in  1   asynchronous, active-high reset
//   bus    if_stage_if.master
//          stall/flush from hazard unit, redirect/target from D,
//          pc_f/instr_f to/from IM, instr_d/pc_d/pc8_d/valid_d/adel_d to D.
// The branch delay slot is whatever sits in F when the redirect arrives; it is
// captured normally, so redirect never flushes IF/ID by itself.
// -----------------------------------------------------------------------------
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned IM_DEPTH = IM_DEPTH_DEFAULT
) (
  input logic        clk,
  input logic        reset,
  if_stage_if.master bus
);

  logic [31:0] w_pc_f;
  logic        w_adel_f;
  logic [31:0] w_instr_f;

  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic        r_valid_d;
  logic        r_adel_d;

  logic [31:0] w_instr_d_next;
  logic [31:0] w_pc_d_next;
  logic        w_valid_d_next;
  logic        w_adel_d_next;

  if_stage_pc_unit #(
    .RESET_PC (RESET_PC)
  ) u_pc_unit (
    .clk        (clk),
    .reset      (reset),
    .i_stall    (bus.stall),
    .i_redirect (bus.redirect),
    .i_target   (bus.target),
    .o_pc       (w_pc_f)
  );

  // Illegal fetches still advance through the pipe so the exception is
  // raised in order, but the word from IM is meaningless and is replaced.
  assign w_adel_f  = addr_illegal(w_pc_f, RESET_PC, IM_DEPTH);
  assign w_instr_f = w_adel_f ? NOP : bus.instr_f;

  always_comb begin
    w_instr_d_next = r_instr_d;
    w_pc_d_next    = r_pc_d;
    w_valid_d_next = r_valid_d;
    w_adel_d_next  = r_adel_d;

    if (bus.flush) begin
      // Bubble keeps the current fetch PC for debug/EPC visibility.
      w_instr_d_next = NOP;
      w_pc_d_next    = w_pc_f;
      w_valid_d_next = 1'b0;
      w_adel_d_next  = 1'b0;
    end else if (!bus.stall) begin
      w_instr_d_next = w_instr_f;
      w_pc_d_next    = w_pc_f;
      w_valid_d_next = 1'b1;
      w_adel_d_next  = w_adel_f;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr_d <= NOP;
      r_pc_d    <= 32'h0000_0000;
      r_valid_d <= 1'b0;
      r_adel_d  <= 1'b0;
    end else begin
      r_instr_d <= w_instr_d_next;
      r_pc_d    <= w_pc_d_next;
      r_valid_d <= w_valid_d_next;
      r_adel_d  <= w_adel_d_next;
    end
  end

  assign bus.pc_f    = w_pc_f;
  assign bus.instr_d = r_instr_d;
  assign bus.pc_d    = r_pc_d;
  assign bus.pc8_d   = r_pc_d + 32'd8;  // jal/jalr link value
  assign bus.valid_d = r_valid_d;
  assign bus.adel_d  = r_adel_d;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  typedef struct {
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic        valid_d;
    logic        adel_d;
  } exp_t;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] target;
    exp_t        exp;
  } vec_t;

  logic clk;
  logic reset;

  int checks;
  int failures;

  vec_t tbl[$];
  exp_t sb[$];

  if_stage_if u_if ();

  if_stage #(
    .RESET_PC (32'h0000_3000),
    .IM_DEPTH (4096)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  // Instruction memory model: every word is distinct and non-zero.
  function automatic logic [31:0] im_word(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  assign u_if.instr_f = im_word(u_if.pc_f);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, " pc_f"},    u_if.pc_f,    e.pc_f);
    chk({tag, " instr_d"}, u_if.instr_d, e.instr_d);
    chk({tag, " pc_d"},    u_if.pc_d,    e.pc_d);
    chk({tag, " pc8_d"},   u_if.pc8_d,   e.pc_d + 32'd8);
    chk({tag, " valid_d"}, {31'd0, u_if.valid_d}, {31'd0, e.valid_d});
    chk({tag, " adel_d"},  {31'd0, u_if.adel_d},  {31'd0, e.adel_d});
  endtask

  function automatic vec_t mk(input logic st, input logic fl, input logic rd,
                              input logic [31:0] tg, input logic [31:0] pc,
                              input logic [31:0] ins, input logic [31:0] pcd,
                              input logic v, input logic ad);
    vec_t r;
    r.stall = st; r.flush = fl; r.redirect = rd; r.target = tg;
    r.exp.pc_f = pc; r.exp.instr_d = ins; r.exp.pc_d = pcd;
    r.exp.valid_d = v; r.exp.adel_d = ad;
    return r;
  endfunction

  // Drive one vector, let one edge pass, then compare against the scoreboard.
  task automatic apply(input string tag, input vec_t v);
    exp_t e;
    u_if.stall    = v.stall;
    u_if.flush    = v.flush;
    u_if.redirect = v.redirect;
    u_if.target   = v.target;
    sb.push_back(v.exp);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty got=0 exp=1", tag);
    end else begin
      e = sb.pop_front();
      chk_all(tag, e);
    end
  endtask

  initial begin
    exp_t rst_exp;
    checks   = 0;
    failures = 0;

    //          st fl rd target        pc_f          instr_d                pc_d          v  ad
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h3004,     im_word(32'h3000),     32'h3000,     1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h3008,     im_word(32'h3004),     32'h3004,     1, 0));
    tbl.push_back(mk(0, 0, 1, 32'h3100,     32'h3100,     im_word(32'h3008),     32'h3008,     1, 0));
    tbl.push_back(mk(0, 0, 1, 32'h3008,     32'h3008,     im_word(32'h3100),     32'h3100,     1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h300C,     im_word(32'h3008),     32'h3008,     1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h3010,     im_word(32'h300C),     32'h300C,     1, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        32'h3010,     im_word(32'h300C),     32'h300C,     1, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        32'h3010,     im_word(32'h300C),     32'h300C,     1, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        32'h3010,     im_word(32'h300C),     32'h300C,     1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h3014,     im_word(32'h3010),     32'h3010,     1, 0));
    tbl.push_back(mk(1, 0, 1, 32'h3200,     32'h3014,     im_word(32'h3010),     32'h3010,     1, 0));
    tbl.push_back(mk(1, 0, 1, 32'h3300,     32'h3014,     im_word(32'h3010),     32'h3010,     1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h3300,     im_word(32'h3014),     32'h3014,     1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h3304,     im_word(32'h3300),     32'h3300,     1, 0));
    tbl.push_back(mk(1, 1, 0, 32'h0,        32'h3304,     32'h0,                 32'h3304,     0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h3308,     im_word(32'h3304),     32'h3304,     1, 0));
    tbl.push_back(mk(0, 1, 1, 32'h3400,     32'h3400,     32'h0,                 32'h3308,     0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h3404,     im_word(32'h3400),     32'h3400,     1, 0));
    tbl.push_back(mk(0, 0, 1, 32'h3002,     32'h3002,     im_word(32'h3404),     32'h3404,     1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h3006,     32'h0,                 32'h3002,     1, 1));
    tbl.push_back(mk(0, 0, 1, 32'h2FFC,     32'h2FFC,     32'h0,                 32'h3006,     1, 1));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h3000,     32'h0,                 32'h2FFC,     1, 1));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h3004,     im_word(32'h3000),     32'h3000,     1, 0));
    tbl.push_back(mk(0, 0, 1, 32'h6FFC,     32'h6FFC,     im_word(32'h3004),     32'h3004,     1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h7000,     im_word(32'h6FFC),     32'h6FFC,     1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h7004,     32'h0,                 32'h7000,     1, 1));
    tbl.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,               32'h7004,     1, 1));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0000_0000, 32'h0,                32'hFFFF_FFFC, 1, 1));
    // Park a redirect under stall; reset below must discard it.
    tbl.push_back(mk(1, 0, 1, 32'h3500,     32'h0000_0000, 32'h0,                32'hFFFF_FFFC, 1, 1));

    rst_exp.pc_f = 32'h3000; rst_exp.instr_d = 32'h0; rst_exp.pc_d = 32'h0;
    rst_exp.valid_d = 1'b0;  rst_exp.adel_d = 1'b0;

    u_if.stall = 0; u_if.flush = 0; u_if.redirect = 0; u_if.target = 32'h0;
    reset = 1'b1;
    #2;
    chk_all("reset", rst_exp);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

    // Asynchronous reset mid-cycle while stalled with a pending redirect.
    #3;
    reset = 1'b1;
    #1;
    chk_all("async_reset", rst_exp);
    u_if.stall = 0; u_if.redirect = 0; u_if.target = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    apply("post_reset", mk(0, 0, 0, 32'h0, 32'h3004, im_word(32'h3000), 32'h3000, 1, 0));
    apply("post_reset2", mk(0, 0, 0, 32'h0, 32'h3008, im_word(32'h3004), 32'h3004, 1, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
